cordic_iter_ctrl: RTL and testbench

Iterative CORDIC engine built around a single time-multiplexed micro-rotation stage. It replaces an unrolled NUM_ITER-stage CORDIC pipeline where area matters more than throughput. Operands are accepted through a valid/ready handshake, rotated over NUM_ITER clock cycles, and presented on a held valid/ready output port. The block contains the iteration counter, the arctangent constant table, the control FSM and output saturation.

---
 rtl/cordic_iter_ctrl.sv | 159 +++++++++++++++
 tb/tb_cordic_iter_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC engine: one shared micro-rotation stage reused for NUM_ITER cycles,
// with valid/ready handshakes on both sides and saturated W-bit result registers.
module cordic_iter_ctrl #(
    parameter int unsigned NUM_ITER      = 12,
    parameter int unsigned FUNC_WIDTH    = 1,
    parameter int unsigned DATA_OP_WIDTH = 18
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic [FUNC_WIDTH-1:0]           i_func,
    input  logic signed [DATA_OP_WIDTH-1:0] i_x,
    input  logic signed [DATA_OP_WIDTH-1:0] i_y,
    input  logic signed [DATA_OP_WIDTH-1:0] i_z,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic signed [DATA_OP_WIDTH-1:0] o_x,
    output logic signed [DATA_OP_WIDTH-1:0] o_y,
    output logic signed [DATA_OP_WIDTH-1:0] o_z,
    output logic                            o_busy
);

    localparam int unsigned W      = DATA_OP_WIDTH;
    localparam int unsigned XW     = W + 2;
    localparam int unsigned ITER_W = $clog2(NUM_ITER);
    localparam int unsigned RND_SH = 32 - W;
    localparam logic [32:0] RND_ADD = (W < 32) ? (33'd1 << (31 - W)) : 33'd0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_nx;

    logic signed [XW-1:0]  x_q, y_q, x_sh, y_sh, x_nx, y_nx;
    logic signed [W-1:0]   z_q, z_nx, a_i;
    logic                  mode_q;
    logic                  d_pos;
    logic                  last_iter;
    logic [ITER_W-1:0]     iter_q;

    // atan(2^-i) with pi = 2^31
    function automatic logic [31:0] atan_tab32(input logic [3:0] idx);
        case (idx)
            4'd0:    return 32'd536870912;
            4'd1:    return 32'd316933406;
            4'd2:    return 32'd167458907;
            4'd3:    return 32'd85004756;
            4'd4:    return 32'd42667331;
            4'd5:    return 32'd21354465;
            4'd6:    return 32'd10679838;
            4'd7:    return 32'd5340245;
            4'd8:    return 32'd2670163;
            4'd9:    return 32'd1335087;
            4'd10:   return 32'd667544;
            4'd11:   return 32'd333772;
            4'd12:   return 32'd166886;
            4'd13:   return 32'd83443;
            4'd14:   return 32'd41722;
            default: return 32'd20861;
        endcase
    endfunction

    // Scale the 32-bit entry to W bits, rounding half up
    function automatic logic signed [W-1:0] atan_w(input logic [3:0] idx);
        logic [32:0] sum;
        sum = {1'b0, atan_tab32(idx)} + RND_ADD;
        return W'(sum >> RND_SH);
    endfunction

    function automatic logic signed [W-1:0] sat(input logic signed [XW-1:0] v);
        if (v[XW-1:W-1] == '0 || v[XW-1:W-1] == '1)
            return v[W-1:0];
        else if (v[XW-1])
            return {1'b1, {(W-1){1'b0}}};
        else
            return {1'b0, {(W-1){1'b1}}};
    endfunction

    always_comb begin
        x_sh  = x_q >>> iter_q;
        y_sh  = y_q >>> iter_q;
        a_i   = atan_w(4'(iter_q));
        d_pos = mode_q ? (x_q[XW-1] != y_q[XW-1]) : ~z_q[W-1];
        if (d_pos) begin
            x_nx = x_q - y_sh;
            y_nx = y_q + x_sh;
            z_nx = z_q - a_i;
        end else begin
            x_nx = x_q + y_sh;
            y_nx = y_q - x_sh;
            z_nx = z_q + a_i;
        end
    end

    assign last_iter = (iter_q == ITER_W'(NUM_ITER - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        o_ready  = 1'b0;
        o_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) state_nx = RUN;
            end
            RUN: begin
                if (last_iter) state_nx = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        o_busy = ~o_ready;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            mode_q <= 1'b0;
            iter_q <= '0;
            o_x    <= '0;
            o_y    <= '0;
            o_z    <= '0;
        end else begin
            if (state_q == IDLE && i_valid) begin
                x_q    <= {{2{i_x[W-1]}}, i_x};
                y_q    <= {{2{i_y[W-1]}}, i_y};
                z_q    <= i_z;
                mode_q <= i_func[0];
                iter_q <= '0;
            end else if (state_q == RUN) begin
                x_q    <= x_nx;
                y_q    <= y_nx;
                z_q    <= z_nx;
                iter_q <= iter_q + 1'b1;
                // Results are captured straight from the final rotation so DONE drives registers
                if (last_iter) begin
                    o_x <= sat(x_nx);
                    o_y <= sat(y_nx);
                    o_z <= z_nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Directed bench for cordic_iter_ctrl (W=18, NUM_ITER=12) with an integer reference model.
module tb_cordic_iter_ctrl;

    localparam int unsigned N = 12;
    localparam int unsigned W = 18;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                i_valid = 1'b0;
    logic                i_ready = 1'b0;
    logic [0:0]          i_func = '0;
    logic signed [W-1:0] i_x = '0, i_y = '0, i_z = '0;
    logic                o_ready, o_valid, o_busy;
    logic signed [W-1:0] o_x, o_y, o_z;

    int n_assert = 0;
    int n_fail   = 0;

    longint atan32 [16] = '{536870912, 316933406, 167458907, 85004756, 42667331, 21354465,
                            10679838, 5340245, 2670163, 1335087, 667544, 333772,
                            166886, 83443, 41722, 20861};

    always #5 clk = ~clk;

    cordic_iter_ctrl #(
        .NUM_ITER(N),
        .FUNC_WIDTH(1),
        .DATA_OP_WIDTH(W)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_func(i_func),
        .i_x(i_x),
        .i_y(i_y),
        .i_z(i_z),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_x(o_x),
        .o_y(o_y),
        .o_z(o_z),
        .o_busy(o_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input logic signed [63:0] obs, input longint lo, input longint hi);
        n_assert++;
        assert (obs >= lo && obs <= hi)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    function automatic longint sat18(input longint v);
        if (v > 131071)  return 131071;
        if (v < -131072) return -131072;
        return v;
    endfunction

    function automatic void cordic_ref(input bit f, input longint x0, input longint y0, input longint z0,
                                       output longint xr, output longint yr, output longint zr);
        longint x, y, z, xn, yn, a;
        bit     d_pos;
        x = x0;
        y = y0;
        z = z0;
        for (int i = 0; i < N; i++) begin
            a = (atan32[i] + 64'sd8192) >>> 14;
            d_pos = f ? ((x < 0) != (y < 0)) : (z >= 0);
            if (d_pos) begin
                xn = x - (y >>> i);
                yn = y + (x >>> i);
                z  = z - a;
            end else begin
                xn = x + (y >>> i);
                yn = y - (x >>> i);
                z  = z + a;
            end
            x = xn;
            y = yn;
            z = z & 64'sh3FFFF;
            if (z >= 64'sh20000) z = z - 64'sh40000;
        end
        xr = sat18(x);
        yr = sat18(y);
        zr = z;
    endfunction

    task automatic check_result(input string tag, input bit f, input longint x0, input longint y0, input longint z0);
        longint ex, ey, ez;
        cordic_ref(f, x0, y0, z0, ex, ey, ez);
        chk({tag, "_x"}, o_x, ex);
        chk({tag, "_y"}, o_y, ey);
        chk({tag, "_z"}, o_z, ez);
    endtask

    task automatic send(input bit f, input int x, input int y, input int z);
        i_func  = f;
        i_x     = W'(x);
        i_y     = W'(y);
        i_z     = W'(z);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget, output int cycles);
        cycles = 0;
        while (o_valid !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
        chk({tag, "_valid_seen"}, o_valid, 1);
    endtask

    task automatic consume();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("handshake_ready", o_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int     cyc;
        int     n_got;
        int     idx_send;
        int     last_res;
        int     q[$];
        bit     was_ready;
        bit     sf [8];
        int     sx [8], sy [8], sz [8];
        longint ex, ey, ez;

        // Reset state
        #12;
        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_x", o_x, 0);
        chk("rst_y", o_y, 0);
        chk("rst_z", o_z, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Rotation by 45 degrees, latency and back-pressure
        send(0, 10000, 0, 32768);
        chk("rot_ready_low", o_ready, 0);
        chk("rot_busy", o_busy, 1);
        for (int c = 1; c <= N; c++) begin
            tick();
            chk("rot_latency", o_valid, (c == N) ? 1 : 0);
        end
        chk_rng("rot_x_range", o_x, 11640, 11648);
        chk_rng("rot_y_range", o_y, 11640, 11648);
        chk_rng("rot_z_range", o_z, -16, 16);
        cordic_ref(0, 10000, 0, 32768, ex, ey, ez);
        for (int c = 0; c < 20; c++) begin
            i_valid = (c == 5);
            i_func  = 1'b1;
            i_x     = W'(-777);
            i_y     = W'(555);
            i_z     = W'(1234);
            tick();
            chk("bp_valid", o_valid, 1);
            chk("bp_ready", o_ready, 0);
            chk("bp_x", o_x, ex);
            chk("bp_y", o_y, ey);
            chk("bp_z", o_z, ez);
        end
        i_valid = 1'b0;
        consume();
        chk("bp_release_valid", o_valid, 0);
        chk("bp_release_busy", o_busy, 0);

        // Vectoring
        send(1, 10000, 10000, 0);
        wait_valid("vec", 40, cyc);
        chk("vec_latency", cyc, N);
        chk_rng("vec_x_range", o_x, 23285, 23293);
        chk_rng("vec_y_range", o_y, -8, 8);
        chk_rng("vec_z_range", o_z, 32752, 32784);
        check_result("vec", 1, 10000, 10000, 0);
        consume();

        // Saturation
        send(0, 131071, 131071, 0);
        wait_valid("sat", 40, cyc);
        chk("sat_x", o_x, 131071);
        chk("sat_y", o_y, 131071);
        check_result("sat", 0, 131071, 131071, 0);
        consume();

        // Asynchronous reset in the middle of RUN
        send(0, 5000, -3000, 20000);
        for (int c = 0; c < 5; c++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_ready", o_ready, 1);
        chk("arst_busy", o_busy, 0);
        chk("arst_x", o_x, 0);
        chk("arst_y", o_y, 0);
        chk("arst_z", o_z, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(1, 20000, -15000, 100);
        chk("arst_accept", o_ready, 0);
        wait_valid("arst_op", 40, cyc);
        chk("arst_latency", cyc, N);
        check_result("arst_op", 1, 20000, -15000, 100);
        consume();

        // Back-to-back random stream with i_ready tied high
        for (int k = 0; k < 8; k++) begin
            sf[k] = 1'($urandom_range(1));
            sx[k] = int'($urandom_range(262143)) - 131072;
            sy[k] = int'($urandom_range(262143)) - 131072;
            sz[k] = int'($urandom_range(262143)) - 131072;
        end
        i_ready   = 1'b1;
        idx_send  = 0;
        n_got     = 0;
        last_res  = -1;
        cyc       = 0;
        was_ready = o_ready;
        i_func    = sf[0];
        i_x       = W'(sx[0]);
        i_y       = W'(sy[0]);
        i_z       = W'(sz[0]);
        i_valid   = 1'b1;
        while (n_got < 8 && cyc < 400) begin
            tick();
            cyc++;
            if (was_ready && i_valid) begin
                q.push_back(idx_send);
                idx_send++;
                if (idx_send < 8) begin
                    i_func = sf[idx_send];
                    i_x    = W'(sx[idx_send]);
                    i_y    = W'(sy[idx_send]);
                    i_z    = W'(sz[idx_send]);
                end else begin
                    i_valid = 1'b0;
                end
            end
            if (o_valid === 1'b1) begin
                if (q.size() > 0) begin
                    int k;
                    k = q.pop_front();
                    check_result("stream", sf[k], sx[k], sy[k], sz[k]);
                end else begin
                    chk("stream_unexpected_result", o_valid, 0);
                end
                if (n_got > 0) chk("stream_spacing", cyc - last_res, N + 2);
                last_res = cyc;
                n_got++;
            end
            was_ready = o_ready;
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        chk("stream_count", n_got, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
